mem_arbiter: RTL and testbench

Single-port memory arbiter between instruction fetch (IF) and the MEM stage (LW/SW) of the five-stage MIPS pipeline. It owns the one external SRAM port, grants it to one requester at a time, sequences a fixed-latency access with a wait-state counter, and returns a one-cycle acknowledge with registered read data. It also drives per-requester stall signals that the pipeline control uses to freeze PC/IF-ID or EX/MEM while an access is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared state/owner types and constants for the single-port memory arbiter.
package mem_arbiter_pkg;

  localparam logic        RST_ENABLE = 1'b0;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_OWN_NONE,
    ARB_OWN_IF,
    ARB_OWN_MEM
  } arb_owner_t;

  function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the external SRAM port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              if_stall_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ack_o;
  logic              mem_stall_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  ram_rdata_i,
    output if_rdata_o, if_ack_o, if_stall_o,
    output mem_rdata_o, mem_ack_o, mem_stall_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output ram_rdata_i,
    input  if_rdata_o, if_ack_o, if_stall_o,
    input  mem_rdata_o, mem_ack_o, mem_stall_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the MEM stage.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed MEM-over-IF priority.
module mem_arbiter #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;

  arb_state_t        state, state_nxt;
  arb_owner_t        owner;
  logic [CNT_W-1:0]  cnt;
  logic              ce_q, we_q, if_ack_q, mem_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, mem_rdata_q;
  logic              mem_wins, grant_if, grant_mem;

`ifdef MEM_ARB_RR_EN
  // last_mem=0 after reset means IF was "last", so MEM takes the first tie.
  logic last_mem;
  assign mem_wins = bus.mem_req_i & (~bus.if_req_i | ~last_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      last_mem <= 1'b0;
    end else if (grant_mem) begin
      last_mem <= 1'b1;
    end else if (grant_if) begin
      last_mem <= 1'b0;
    end
  end
`else
  assign mem_wins = bus.mem_req_i;
`endif

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      ARB_IDLE: begin
        grant_mem = mem_wins;
        grant_if  = bus.if_req_i & ~mem_wins;
        if (grant_mem | grant_if) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: if (cnt == '0) state_nxt = ARB_DONE;
      ARB_DONE:   state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state       <= ARB_IDLE;
      owner       <= ARB_OWN_NONE;
      cnt         <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_mem | grant_if) begin
            owner   <= grant_mem ? ARB_OWN_MEM : ARB_OWN_IF;
            addr_q  <= grant_mem ? bus.mem_addr_i : bus.if_addr_i;
            wdata_q <= grant_mem ? bus.mem_wdata_i : '0;
            we_q    <= grant_mem & bus.mem_we_i;
            cnt     <= wait_load(WAIT_CYCLES);
            ce_q    <= 1'b1;
          end
        end
        ARB_ACCESS: begin
          // Ack is raised on the ACCESS->DONE edge so it is high for exactly the DONE cycle.
          if (cnt == '0) begin
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            if_ack_q  <= (owner == ARB_OWN_IF);
            mem_ack_q <= (owner == ARB_OWN_MEM);
            if (owner == ARB_OWN_IF) if_rdata_q <= bus.ram_rdata_i;
            if (owner == ARB_OWN_MEM && !we_q) mem_rdata_q <= bus.ram_rdata_i;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARB_DONE: owner <= ARB_OWN_NONE;
        default:  owner <= ARB_OWN_NONE;
      endcase
    end
  end

  assign bus.ram_ce_o    = ce_q;
  assign bus.ram_we_o    = we_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
  assign bus.mem_stall_o = bus.mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level memory model, directed and random traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W     = 2;
  localparam int LIMIT = 3 * (W + 2);
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          ack_at;
  } exp_t;
  exp_t if_q[$];
  exp_t mem_q[$];

  // Reference model: word store plus the value mem_rdata_o should be holding.
  logic [31:0] sram    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_mem_rdata = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // SRAM model: read data is only valid in the last cycle of a W-cycle enable window.
  int sr_run = 0;
  always @(negedge clk) begin
    if (bus.ram_ce_o === 1'b1) begin
      if (bus.ram_we_o) sram[bus.ram_addr_o] = bus.ram_wdata_o;
      bus.ram_rdata_i = (!bus.ram_we_o && sr_run == W - 1) ? sram_rd(bus.ram_addr_o) : BAD;
      sr_run++;
    end else begin
      bus.ram_rdata_i = BAD;
      sr_run = 0;
    end
  end
  assign bus1.ram_rdata_i = bus1.ram_ce_o ? 32'h8C22_0004 : BAD;

  int ce_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      check("if_stall", 32'(bus.if_stall_o), 32'(bus.if_req_i & ~bus.if_ack_o));
      check("mem_stall", 32'(bus.mem_stall_o), 32'(bus.mem_req_i & ~bus.mem_ack_o));
      if (bus.ram_ce_o) ce_run++;
      else if (ce_run != 0) begin
        check("ce_width", ce_run, W);
        ce_run = 0;
      end
      if (bus.if_ack_o) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_ack_unexpected: got ack=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = if_q.pop_front();
          check("if_rdata", bus.if_rdata_o, e.data);
          if (e.ack_at >= 0) check("if_ack_cycle", cyc, e.ack_at);
          else check("if_latency_ok", 32'(cyc - e.issue <= LIMIT), 32'd1);
        end
      end
      if (bus.mem_ack_o) begin
        if (mem_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_ack_unexpected: got ack=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = mem_q.pop_front();
          check("mem_rdata", bus.mem_rdata_o, e.data);
          if (e.ack_at >= 0) check("mem_ack_cycle", cyc, e.ack_at);
          else check("mem_latency_ok", 32'(cyc - e.issue <= LIMIT), 32'd1);
        end
      end
    end else begin
      ce_run = 0;
    end
  end

  task automatic if_read(input logic [31:0] a, input int ack_off);
    exp_t e;
    int n;
    @(posedge clk); #1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    e.data   = ref_rd(a);
    e.issue  = cyc;
    e.ack_at = (ack_off >= 0) ? cyc + ack_off : -1;
    if_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_ack_o && n < LIMIT + 4);
    if (!bus.if_ack_o) begin
      checks++; failures++;
      $display("FAIL if_timeout: got no ack after %0d cycles expected ack", n);
      void'(if_q.pop_back());
    end
  endtask

  task automatic if_idle();
    @(posedge clk); #1;
    bus.if_req_i = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int ack_off);
    exp_t e;
    int n;
    @(posedge clk); #1;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = we;
    bus.mem_addr_i  = a;
    bus.mem_wdata_i = d;
    if (we) ref_mem[a] = d;
    else ref_mem_rdata = ref_rd(a);
    e.data   = ref_mem_rdata;
    e.issue  = cyc;
    e.ack_at = (ack_off >= 0) ? cyc + ack_off : -1;
    mem_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_ack_o && n < LIMIT + 4);
    if (!bus.mem_ack_o) begin
      checks++; failures++;
      $display("FAIL mem_timeout: got no ack after %0d cycles expected ack", n);
      void'(mem_q.pop_back());
    end
  endtask

  task automatic mem_idle();
    @(posedge clk); #1;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    bus1.if_req_i = 1'b0; bus1.if_addr_i = '0;
    bus1.mem_req_i = 1'b0; bus1.mem_we_i = 1'b0; bus1.mem_addr_i = '0; bus1.mem_wdata_i = '0;
    sram[32'h40]    = 32'h3C01_1234;
    ref_mem[32'h40] = 32'h3C01_1234;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce", 32'(bus.ram_ce_o), 0);
    check("rst_we", 32'(bus.ram_we_o), 0);
    check("rst_addr", bus.ram_addr_o, 0);
    check("rst_wdata", bus.ram_wdata_o, 0);
    check("rst_if_ack", 32'(bus.if_ack_o), 0);
    check("rst_mem_ack", 32'(bus.mem_ack_o), 0);
    check("rst_if_rdata", bus.if_rdata_o, 0);
    check("rst_mem_rdata", bus.mem_rdata_o, 0);
    rst = 1'b1;

    // Directed: IF fetch, SW, then LW of the stored word.
    if_read(32'h0000_0040, W + 1);   if_idle();
    mem_op(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, W + 1); mem_idle();
    mem_op(1'b0, 32'h0000_0100, 32'h0, W + 1);         mem_idle();

    // Reset in the middle of an access.
    @(posedge clk); #1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0044;
    @(posedge clk); #1;
    check("ce_before_reset", 32'(bus.ram_ce_o), 1);
    rst = 1'b0;
    ref_mem_rdata = '0;
    #1;
    check("mid_rst_ce", 32'(bus.ram_ce_o), 0);
    check("mid_rst_addr", bus.ram_addr_o, 0);
    check("mid_rst_if_ack", 32'(bus.if_ack_o), 0);
    check("mid_rst_if_rdata", bus.if_rdata_o, 0);
    check("mid_rst_mem_rdata", bus.mem_rdata_o, 0);
    check("mid_rst_if_stall", 32'(bus.if_stall_o), 1);
    bus.if_req_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    repeat (W + 3) @(posedge clk);

    // Tie after reset: the monitor flags any ack left over from the abandoned access.
    fork
      begin
        mem_op(1'b0, 32'h0000_0104, 32'h0, W + 1);
`ifdef MEM_ARB_RR_EN
        mem_op(1'b1, 32'h0000_0108, 32'h1234_5678, 2 * W + 3);
`else
        mem_op(1'b1, 32'h0000_0108, 32'h1234_5678, W + 1);
`endif
        mem_idle();
      end
      begin
`ifdef MEM_ARB_RR_EN
        if_read(32'h0000_0080, 2 * W + 3);
`else
        if_read(32'h0000_0080, 3 * W + 5);
`endif
        if_idle();
      end
    join

    // Random concurrent traffic; MEM always idles at least one cycle between accesses.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if_read(32'h0000_2000 + (32'($urandom_range(0, 63)) << 2), -1);
          if ($urandom_range(0, 2) != 0) begin
            if_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
        end
        if_idle();
      end
      begin
        for (int j = 0; j < 60; j++) begin
          mem_op(1'($urandom_range(0, 1)), 32'h0000_0100 + (32'($urandom_range(0, 7)) << 2),
                 $urandom, -1);
          mem_idle();
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    repeat (LIMIT) @(posedge clk);
    check("if_q_drained", if_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    foreach (ref_mem[k]) check("sram_content", sram_rd(k), ref_mem[k]);

    // WAIT_CYCLES=1 instance: single LW, enable for one cycle, ack two cycles after request.
    @(posedge clk); #1;
    bus1.mem_req_i  = 1'b1;
    bus1.mem_addr_i = 32'h0000_0200;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("w1_ce", 32'(bus1.ram_ce_o), 32'(k == 1));
      check("w1_ack", 32'(bus1.mem_ack_o), 32'(k == 2));
      if (k == 2) begin
        check("w1_rdata", bus1.mem_rdata_o, 32'h8C22_0004);
        check("w1_ack_cycle", cyc - c0, 2);
        bus1.mem_req_i = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
